sprite_plotter: RTL and testbench
=================================

# sprite_plotter

Pixel-generation stage directly downstream of the draw/wait/erase sequencer. On each accepted `start` it latches a drawing operation (`op`) and a sprite origin, then emits one VGA-adapter write per cycle covering a SIZE×SIZE square in the draw or erase colour. It signals completion with a one-cycle `done` pulse and drives the `x`/`y`/`colour`/`plot` inputs of the 160×120 VGA adapter.

## Interface
- `SIZE`, 5: sprite edge length in pixels (1..15); one frame of work is SIZE*SIZE pixels.
- `X_MAX`, 159: largest visible x coordinate.
- `Y_MAX`, 119: largest visible y coordinate.
- `DRAW_COLOUR`, 3'b111: colour emitted for op 2'b00.
- `ERASE_COLOUR`, 3'b000: colour emitted for op 2'b01.

- `clk`  in  1  single system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe, sampled each cycle.
- `op`  in  2  2'b00 draw, 2'b01 erase, 2'b10/2'b11 invalid.
- `x_in`  in  8  sprite origin x (top-left).
- `y_in`  in  7  sprite origin y (top-left).
- `busy`  out  1  high while in PLOT or DONE.
- `done`  out  1  one-cycle pulse after the last pixel.
- `vga_x`  out  8  pixel x to the adapter.
- `vga_y`  out  7  pixel y to the adapter.
- `colour`  out  3  pixel colour.
- `plot`  out  1  adapter write enable.

## Operation
- States are IDLE, PLOT, and DONE. Reset forces IDLE.
- IDLE, `start`=1, `op` ∈ {00,01}:
  - Latch `x_in`, `y_in`, and colour (chosen from `op`).
  - Clear column/row counters `col`=`row`=0.
  - Go to PLOT.
- IDLE, `start`=1, `op` ∈ {10,11}: ignore the request and stay in IDLE. No plot, no done.
- PLOT, each cycle:
  - `vga_x` = base_x + col and `vga_y` = base_y + row, computed 9-bit/8-bit wide. There is no wrap-around.
  - `plot`=1 only if the sum is ≤ X_MAX and ≤ Y_MAX. Off-screen pixels set `plot`=0 but still consume a cycle.
  - `col` increments. When `col`=SIZE-1 it returns to 0 and `row` increments (raster order, x fastest).
  - After the pixel with `row`=SIZE-1 and `col`=SIZE-1, go to DONE.
- DONE: one cycle with `done`=1 and `plot`=0, then IDLE.
- `start` in PLOT or DONE is ignored; it is not queued.
- Inputs `x_in`/`y_in`/`op` may change freely after acceptance; only the latched copies are used.
- Reset values for every output: `busy`=0, `done`=0, `plot`=0, `vga_x`=0, `vga_y`=0, `colour`=0. Internal counters are also 0.

## Timing
- All outputs are registered; no combinational path runs from the inputs to the outputs.
- `start` is accepted at edge 0. The first pixel is presented in cycle 1 (registered after edge 0).
- Pixel k (0-based) is presented in cycle k+1. The last pixel is in cycle SIZE*SIZE (cycle 25 by default).
- `done` is high in cycle SIZE*SIZE+1 (cycle 26).
- `busy` is high in cycles 1..SIZE*SIZE+1. The earliest next accepted `start` is sampled in cycle SIZE*SIZE+2.
- Throughput: one sprite per SIZE*SIZE+2 cycles. This fits inside the upstream sequencer's 25-cycle draw window plus its wait period.
- Reset asserted mid-PLOT: outputs clear immediately (asynchronously). No `done` is issued. After release the block sits in IDLE awaiting a fresh `start`.

## Test plan
- **Draw:** reset, then `start`, `op`=00, x=10, y=20. Expect exactly 25 `plot` cycles covering x 10..14 × y 20..24 in raster order, all with `colour`=111. `done` is a single pulse in cycle 26 and `busy` drops in cycle 27.
- **Erase:** `op`=01, x=0, y=0. Expect 25 plots over (0..4, 0..4) with `colour`=000, then `done` in cycle 26.
- **Clipping:** x=157, y=117. Expect `plot`=1 only for x 157..159 and y 117..119, which is 9 pixels. The remaining 16 cycles have `plot`=0, and `done` still arrives in cycle 26.
- **Busy/ignored requests:** pulse `start` again in cycles 5 and 26 (the DONE cycle) with x=50. No restart may occur and the pixel sequence is unchanged. Also `op`=10 with `start` in IDLE must leave `busy`, `plot`, and `done` at 0 for 30 cycles.
- **Reset mid-operation:** assert `reset_n`=0 in cycle 12 of a draw. All outputs are 0 immediately and no `done` is issued. After release, a new `start` with x=30, y=40 produces a full, correct 25-pixel sprite.
- **Back-to-back:** `start` in the first cycle after `busy` falls. The second sprite begins with no lost or duplicated pixels, and the gap between the two `done` pulses is 27 cycles.

Source files
------------

// File: rtl/sprite_plotter.sv
// Sprite plotter: on an accepted start, emits one VGA-adapter write per cycle
// over a SIZE x SIZE square in raster order, clipping off-screen pixels.
module sprite_plotter #(
  parameter int         SIZE         = 5,
  parameter int         X_MAX        = 159,
  parameter int         Y_MAX        = 119,
  parameter logic [2:0] DRAW_COLOUR  = 3'b111,
  parameter logic [2:0] ERASE_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] x_in,
  input  logic [6:0] y_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot
);

  typedef enum logic [1:0] {S_IDLE, S_PLOT, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(SIZE - 1);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_col, r_row, w_col_nxt, w_row_nxt;
  logic [7:0] r_base_x;
  logic [6:0] r_base_y;
  logic [2:0] r_colour;

  logic       r_busy, r_done, r_plot;
  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_vga_colour;

  logic       w_accept, w_last;
  logic [7:0] w_bx;
  logic [6:0] w_by;
  logic [8:0] w_sum_x;
  logic [7:0] w_sum_y;
  logic [2:0] w_colour_sel;
  logic       w_busy_nxt, w_done_nxt, w_plot_nxt;
  logic [7:0] w_vga_x_nxt;
  logic [6:0] w_vga_y_nxt;
  logic [2:0] w_vga_colour_nxt;

  assign w_accept = (r_state == S_IDLE) && start && !op[1];
  assign w_last   = (r_col == LAST) && (r_row == LAST);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and next-counter logic
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_PLOT;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end
      end
      S_PLOT: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
        end else if (r_col == LAST) begin
          w_col_nxt = '0;
          w_row_nxt = r_row + 4'd1;
        end else begin
          w_col_nxt = r_col + 4'd1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, one pixel ahead so
  // the first pixel appears in the cycle right after acceptance.
  always_comb begin
    w_bx         = w_accept ? x_in : r_base_x;
    w_by         = w_accept ? y_in : r_base_y;
    w_colour_sel = w_accept ? (op[0] ? ERASE_COLOUR : DRAW_COLOUR) : r_colour;
    w_sum_x      = {1'b0, w_bx} + {5'd0, w_col_nxt};
    w_sum_y      = {1'b0, w_by} + {4'd0, w_row_nxt};

    w_busy_nxt       = (w_state_nxt != S_IDLE);
    w_done_nxt       = (w_state_nxt == S_DONE);
    w_plot_nxt       = 1'b0;
    w_vga_x_nxt      = r_vga_x;
    w_vga_y_nxt      = r_vga_y;
    w_vga_colour_nxt = r_vga_colour;
    if (w_state_nxt == S_PLOT) begin
      w_plot_nxt       = (w_sum_x <= 9'(X_MAX)) && (w_sum_y <= 8'(Y_MAX));
      w_vga_x_nxt      = w_sum_x[7:0];
      w_vga_y_nxt      = w_sum_y[6:0];
      w_vga_colour_nxt = w_colour_sel;
    end
  end

  // Datapath registers: counters, latched request and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_base_x     <= '0;
      r_base_y     <= '0;
      r_colour     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_plot       <= 1'b0;
      r_vga_x      <= '0;
      r_vga_y      <= '0;
      r_vga_colour <= '0;
    end else begin
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      if (w_accept) begin
        r_base_x <= x_in;
        r_base_y <= y_in;
        r_colour <= w_colour_sel;
      end
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_plot       <= w_plot_nxt;
      r_vga_x      <= w_vga_x_nxt;
      r_vga_y      <= w_vga_y_nxt;
      r_vga_colour <= w_vga_colour_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign plot   = r_plot;
  assign vga_x  = r_vga_x;
  assign vga_y  = r_vga_y;
  assign colour = r_vga_colour;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed self-checking bench for sprite_plotter: draw, erase, clipping,
// ignored requests, invalid op, mid-operation reset and back-to-back sprites.
module tb_sprite_plotter;

  localparam int SIZE = 5;
  localparam int NPIX = SIZE * SIZE;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic       busy, done, plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int done_cyc = 0;

  sprite_plotter dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .x_in(x_in), .y_in(y_in),
    .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   busy,   0);
    check({tag, "_done"},   done,   0);
    check({tag, "_plot"},   plot,   0);
    check({tag, "_vga_x"},  vga_x,  0);
    check({tag, "_vga_y"},  vga_y,  0);
    check({tag, "_colour"}, colour, 0);
  endtask

  // Called during the cycle before acceptance; returns at the negedge of cycle NPIX+2.
  task automatic run_sprite(input string tag, input logic [7:0] x0, input logic [6:0] y0,
                            input logic [1:0] op_v, input logic [2:0] col_exp,
                            input int inj_a, input int inj_b, input int exp_plots);
    int plots = 0;
    int ex, ey, k;
    logic exp_p;
    start = 1'b1; op = op_v; x_in = x0; y_in = y0;
    @(posedge clk); #1;
    start = 1'b0; op = 2'b10; x_in = 8'hFF; y_in = 7'h7F;
    for (int c = 1; c <= NPIX + 1; c++) begin
      if (c == inj_a || c == inj_b) begin
        start = 1'b1; op = 2'b00; x_in = 8'd50;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (c <= NPIX) begin
        k  = c - 1;
        ex = int'(x0) + k % SIZE;
        ey = int'(y0) + k / SIZE;
        exp_p = (ex <= 159) && (ey <= 119);
        check({tag, "_plot"}, plot, exp_p);
        if (exp_p) begin
          check({tag, "_x"},   vga_x,  ex);
          check({tag, "_y"},   vga_y,  ey);
          check({tag, "_col"}, colour, col_exp);
        end
        check({tag, "_busy"}, busy, 1);
        check({tag, "_done_early"}, done, 0);
        if (plot) plots++;
      end else begin
        check({tag, "_done"}, done, 1);
        check({tag, "_done_plot"}, plot, 0);
        check({tag, "_done_busy"}, busy, 1);
        done_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, done, 0);
    check({tag, "_idle_plot"}, plot, 0);
    check({tag, "_plots"}, plots, exp_plots);
  endtask

  initial begin
    int first_done;

    #2 reset_n = 1'b0;
    #1 check_all_zero("reset");
    @(posedge clk); @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk) check_all_zero("post_reset");

    // Draw then back-to-back erase: start sampled in the first cycle busy is low.
    run_sprite("draw", 8'd10, 7'd20, 2'b00, 3'b111, 0, 0, 25);
    first_done = done_cyc;
    run_sprite("erase", 8'd0, 7'd0, 2'b01, 3'b000, 0, 0, 25);
    check("b2b_done_gap", done_cyc - first_done, 27);

    run_sprite("clip", 8'd157, 7'd117, 2'b00, 3'b111, 0, 0, 9);

    run_sprite("ignore", 8'd20, 7'd30, 2'b00, 3'b111, 5, 26, 25);

    // Invalid ops in IDLE must be dropped.
    @(posedge clk); #1;
    for (int c = 0; c < 30; c++) begin
      start = 1'b1;
      op = (c < 15) ? 2'b10 : 2'b11;
      x_in = 8'd40; y_in = 7'd40;
      @(negedge clk);
      check("inv_busy", busy, 0);
      check("inv_plot", plot, 0);
      check("inv_done", done, 0);
      @(posedge clk); #1;
    end
    start = 1'b0; op = 2'b00;

    // Reset in cycle 12 of a draw.
    start = 1'b1; op = 2'b00; x_in = 8'd60; y_in = 7'd60;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 12; c++) begin
      @(posedge clk); #1;
    end
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrst");
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_hold_done", done, 0);
      check("midrst_hold_busy", busy, 0);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("midrst_idle_busy", busy, 0);
      check("midrst_idle_done", done, 0);
      check("midrst_idle_plot", plot, 0);
    end
    run_sprite("after_rst", 8'd30, 7'd40, 2'b00, 3'b111, 0, 0, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
